// File: rtl/aes_shiftrows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for Rijndael states of 4, 6 or 8 columns.
// The permutation is pure wiring; a 2-entry output FIFO gives full throughput under backpressure.
module aes_shiftrows_pipe #(
  parameter int NB = 4,
  localparam int W = 32 * NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_inv
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end

  // Rijndael row offsets: the 256-bit block skips offset 2 on rows 2 and 3.
  function automatic int row_shift(input int r);
    if (NB == 8)
      return (r < 2) ? r : r + 1;
    else
      return r;
  endfunction

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      localparam int SH      = row_shift(gi);
      localparam int ROW_LSB = (3 - gi) * 8 * NB;
      localparam int FWD_SRC = (gj + SH) % NB;
      localparam int INV_SRC = (gj + NB - SH) % NB;
      localparam int DST     = ROW_LSB + 8 * (NB - 1 - gj);
      assign fwd_data[DST +: 8] = in_data[ROW_LSB + 8 * (NB - 1 - FWD_SRC) +: 8];
      assign inv_data[DST +: 8] = in_data[ROW_LSB + 8 * (NB - 1 - INV_SRC) +: 8];
    end
  end

  assign shifted = in_inv ? inv_data : fwd_data;

  logic [1:0]   count_reg, count_next;
  logic [W-1:0] data0_reg, data0_next;
  logic [W-1:0] data1_reg, data1_next;
  logic         inv0_reg, inv0_next;
  logic         inv1_reg, inv1_next;
  logic         push, pop;

  // in_ready comes only from the registered count, never from out_ready.
  assign in_ready  = ~count_reg[1];
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = data0_reg;
  assign out_inv   = inv0_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count_reg;
    data0_next = data0_reg;
    data1_next = data1_reg;
    inv0_next  = inv0_reg;
    inv1_next  = inv1_reg;
    case ({push, pop})
      2'b10: begin
        if (count_reg == 2'd0) begin
          data0_next = shifted;
          inv0_next  = in_inv;
        end else begin
          data1_next = shifted;
          inv1_next  = in_inv;
        end
        count_next = count_reg + 2'd1;
      end
      2'b01: begin
        data0_next = data1_reg;
        inv0_next  = inv1_reg;
        data1_next = '0;
        inv1_next  = 1'b0;
        count_next = count_reg - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry: the new result replaces the leaving head.
        data0_next = shifted;
        inv0_next  = in_inv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
      data0_reg <= '0;
      data1_reg <= '0;
      inv0_reg  <= 1'b0;
      inv1_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      data0_reg <= data0_next;
      data1_reg <= data1_next;
      inv0_reg  <= inv0_next;
      inv1_reg  <= inv1_next;
    end
  end

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe: vector table, forward/inverse chaining, backpressure,
// reset flush and a randomized NB=6 scoreboard against a byte-array reference model.
module tb_aes_shiftrows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   in_valid_v, in_inv_v, out_ready_v;
  logic [2:0]   in_ready_v, out_valid_v, out_inv_v;
  logic [255:0] in_data_a [3];
  logic [127:0] out_data4;
  logic [191:0] out_data6;
  logic [255:0] out_data8;

  int total = 0;
  int bad   = 0;

  aes_shiftrows_pipe #(.NB(4)) u_nb4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data_a[0][127:0]), .in_inv(in_inv_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data4), .out_inv(out_inv_v[0])
  );

  aes_shiftrows_pipe #(.NB(6)) u_nb6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data_a[1][191:0]), .in_inv(in_inv_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data6), .out_inv(out_inv_v[1])
  );

  aes_shiftrows_pipe #(.NB(8)) u_nb8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_data(in_data_a[2]), .in_inv(in_inv_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_data(out_data8), .out_inv(out_inv_v[2])
  );

  function automatic int nb_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 6 : 8;
  endfunction

  function automatic logic [255:0] out_of(input int k);
    if (k == 0) return {128'b0, out_data4};
    if (k == 1) return {64'b0, out_data6};
    return out_data8;
  endfunction

  // Reference: unpack into a 4xNB byte grid, rotate each row one byte at a time.
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input logic inv);
    logic [7:0]   st [4][8];
    logic [7:0]   tmp;
    logic [255:0] res;
    int           offs [4];
    offs = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        st[r][c] = d[(3 - r) * 8 * nb + 8 * (nb - 1 - c) +: 8];
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < offs[r]; s++) begin
        if (!inv) begin
          tmp = st[r][0];
          for (int c = 0; c < nb - 1; c++) st[r][c] = st[r][c + 1];
          st[r][nb - 1] = tmp;
        end else begin
          tmp = st[r][nb - 1];
          for (int c = nb - 1; c > 0; c--) st[r][c] = st[r][c - 1];
          st[r][0] = tmp;
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        res[(3 - r) * 8 * nb + 8 * (nb - 1 - c) +: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [255:0] rand_state(input int nb);
    logic [255:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v & ({256{1'b1}} >> (256 - 32 * nb));
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Single transaction with out_ready held high; returns the head one cycle later.
  task automatic xfer(input int k, input logic [255:0] d, input logic inv,
                      output logic [255:0] od, output logic oinv);
    in_data_a[k]   = d;
    in_inv_v[k]    = inv;
    in_valid_v[k]  = 1'b1;
    out_ready_v[k] = 1'b1;
    check("xfer_in_ready", {255'b0, in_ready_v[k]}, 256'd1);
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    check("xfer_out_valid", {255'b0, out_valid_v[k]}, 256'd1);
    od   = out_of(k);
    oinv = out_inv_v[k];
  endtask

  typedef struct {
    int           k;
    logic [255:0] din;
    logic         inv;
    logic [255:0] dout;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] od, od2, exp_d, tx [5];
    logic         oi, oi2, ready_s, ov;
    logic [255:0] exp_q [$];
    logic         exp_inv_q [$];
    int           sent, got, acc, pops, cyc;

    vecs[0] = '{0, 256'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, 1'b1, 256'h8e9f01c6_c64ddc01_01c6a158_9d01c6bc};
    vecs[1] = '{0, 256'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, 1'b0, 256'h8e9f01c6_dc01c64d_01c6a158_c6bc9d01};
    vecs[2] = '{2, 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f, 1'b0,
                   256'h0001020304050607_090a0b0c0d0e0f08_1314151617101112_1c1d1e1f18191a1b};
    vecs[3] = '{2, 256'h0001020304050607_090a0b0c0d0e0f08_1314151617101112_1c1d1e1f18191a1b, 1'b1,
                   256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f};

    rst = 1'b1;
    in_valid_v = '0; in_inv_v = '0; out_ready_v = '0;
    for (int k = 0; k < 3; k++) in_data_a[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", {255'b0, out_valid_v[k]}, 256'd0);
      check("rst_out_data", out_of(k), 256'd0);
      check("rst_out_inv", {255'b0, out_inv_v[k]}, 256'd0);
      check("rst_in_ready", {255'b0, in_ready_v[k]}, 256'd1);
      $display("reset nb=%0d valid=%0b ready=%0b", nb_of(k), out_valid_v[k], in_ready_v[k]);
    end

    for (int i = 0; i < 4; i++) begin
      xfer(vecs[i].k, vecs[i].din, vecs[i].inv, od, oi);
      check("vec_data", od, vecs[i].dout);
      check("vec_inv", {255'b0, oi}, {255'b0, vecs[i].inv});
      $display("vec %0d nb=%0d inv=%0b out=%h", i, nb_of(vecs[i].k), vecs[i].inv, od);
    end

    for (int i = 0; i < 1000; i++) begin
      exp_d = rand_state(4);
      oi    = 1'($urandom % 2);
      xfer(0, exp_d, oi, od, oi2);
      check("chain_first", od, ref_shift(4, exp_d, oi));
      check("chain_tag", {255'b0, oi2}, {255'b0, oi});
      xfer(0, od, ~oi, od2, oi2);
      check("chain_back", od2, exp_d);
      $display("chain %0d inv=%0b in=%h back=%h", i, oi, exp_d[127:0], od2[127:0]);
    end

    // Backpressure: out_ready low for 4 cycles, 5 transactions queued.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) tx[i] = rand_state(4);
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready_v[0] = (c >= 4);
      in_valid_v[0]  = (sent < 5);
      in_data_a[0]   = (sent < 5) ? tx[sent] : '0;
      in_inv_v[0]    = (sent < 5) ? 1'(sent % 2) : 1'b0;
      ready_s = in_ready_v[0];
      ov      = out_valid_v[0];
      if (c == 4) begin
        check("bp_accepts", sent, 2);
        check("bp_in_ready_low", {255'b0, ready_s}, 256'd0);
      end
      if (c >= 1 && c < 4) check("bp_head_stable", out_of(0), ref_shift(4, tx[0], 1'b0));
      if (c >= 4) check("bp_no_gap", {255'b0, ov}, 256'd1);
      if (ov && out_ready_v[0]) begin
        check("bp_order", out_of(0), ref_shift(4, tx[got], 1'(got % 2)));
        check("bp_tag", {255'b0, out_inv_v[0]}, {255'b0, 1'(got % 2)});
        $display("bp tx %0d out=%h", got, out_of(0));
        got++;
      end
      @(posedge clk);
      if (ready_s && in_valid_v[0]) sent++;
      #1;
    end
    in_valid_v[0] = 1'b0;
    check("bp_all_out", got, 5);
    @(posedge clk); #1;
    check("bp_drained", {255'b0, out_valid_v[0]}, 256'd0);

    // Reset with a full buffer and an input pending.
    out_ready_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[0] = 1'b1; in_data_a[0] = rand_state(4);
      @(posedge clk); #1;
    end
    check("full_in_ready", {255'b0, in_ready_v[0]}, 256'd0);
    in_data_a[0] = rand_state(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid_v[0] = 1'b0;
    check("mid_rst_valid", {255'b0, out_valid_v[0]}, 256'd0);
    check("mid_rst_data", out_of(0), 256'd0);
    check("mid_rst_ready", {255'b0, in_ready_v[0]}, 256'd1);
    $display("mid-stream reset valid=%0b ready=%0b", out_valid_v[0], in_ready_v[0]);
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_ghost", {255'b0, out_valid_v[0]}, 256'd0);
    end
    in_valid_v[0] = 1'b1; in_data_a[0] = rand_state(4); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid_v[0] = 1'b0;
    check("rst_drop_push", {255'b0, out_valid_v[0]}, 256'd0);
    $display("push during reset dropped valid=%0b", out_valid_v[0]);

    // Randomized NB=6 stream against the reference queue.
    acc = 0; pops = 0; cyc = 0;
    while (pops < 10000 && cyc < 50000) begin
      in_valid_v[1]  = (acc < 10000) && ($urandom % 4 != 0);
      in_data_a[1]   = rand_state(6);
      in_inv_v[1]    = 1'($urandom % 2);
      out_ready_v[1] = ($urandom % 4 != 0);
      check("rnd_in_ready", {255'b0, in_ready_v[1]}, {255'b0, exp_q.size() < 2});
      check("rnd_out_valid", {255'b0, out_valid_v[1]}, {255'b0, exp_q.size() > 0});
      if (out_valid_v[1] && out_ready_v[1] && exp_q.size() > 0) begin
        check("rnd_data", out_of(1), exp_q[0]);
        check("rnd_inv", {255'b0, out_inv_v[1]}, {255'b0, exp_inv_q[0]});
        $display("rnd tx %0d inv=%0b out=%h", pops, out_inv_v[1], out_of(1));
        void'(exp_q.pop_front());
        void'(exp_inv_q.pop_front());
        pops++;
      end
      if (in_valid_v[1] && in_ready_v[1]) begin
        exp_q.push_back(ref_shift(6, in_data_a[1], in_inv_v[1]));
        exp_inv_q.push_back(in_inv_v[1]);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_v[1] = 1'b0;
    check("rnd_complete", pops, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_shiftrows_pipe.md
# aes_shiftrows_pipe

Parametrised, pipelined ShiftRows / InvShiftRows unit for the Rijndael datapath. It covers block widths of 128, 192 and 256 bits (NB = 4, 6 or 8 columns). Direction is selected per transaction, replacing the fixed combinational 128-bit inverse-only unit. It sits between SubBytes and MixColumns (encrypt) or between AddRoundKey and InvSubBytes (decrypt), behind a valid/ready handshake with a 2-entry output buffer, so it runs at full throughput under backpressure.

## Interface
- NB, default 4: columns per state; legal values 4, 6, 8. Any other value must fail elaboration.
- W, derived as 32*NB: state width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high; one clock, synchronous active-high reset (fixed)
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept an input this cycle
- in_data  in  W  input state
- in_inv  in  1  direction: 1 = InvShiftRows, 0 = ShiftRows
- out_valid  out  1  output transaction present
- out_ready  in  1  downstream accepts
- out_data  out  W  shifted state
- out_inv  out  1  in_inv tag carried with the transaction

## Operation
- State layout is row-major, row 0 in the MSBs.
  - Row r (0..3) occupies in_data[(3-r)*8*NB +: 8*NB].
  - Column c of that row is the byte at in_data[(3-r)*8*NB + 8*(NB-1-c) +: 8], so column 0 is the most significant byte of the row.
- Row offsets C_r:
  - NB=4 or 6: C = 0,1,2,3.
  - NB=8: C = 0,1,3,4.
- Forward: out[r][c] = in[r][(c + C_r) mod NB], i.e. each row rotates left by C_r bytes.
- Inverse: out[r][(c + C_r) mod NB] = in[r][c], i.e. each row rotates right by C_r bytes.
- The permutation is combinational on the input side. The result and its tag are written into a 2-entry FIFO (slot 0 = head).
- Occupancy count is 0..2.
  - in_ready = (count < 2).
  - out_valid = (count > 0).
  - out_data / out_inv = head entry.
- Push occurs on in_valid & in_ready. Pop occurs on out_valid & out_ready.
- Simultaneous push and pop at count = 1: count stays 1. The new entry becomes the head in the cycle after the old head leaves.
- Push at count = 2 cannot occur because in_ready = 0.
- No data-dependent stall. Direction can change every transaction.
- Output order equals input order.

## Timing
- Reset (rst high at a clock edge):
  - count = 0 and both entries are cleared to 0.
  - From the next cycle: out_valid = 0, out_data = 0, out_inv = 0, in_ready = 1.
- Reset mid-operation discards buffered transactions. A push presented in the same cycle as rst is dropped.
- Latency: an input accepted at edge N is presented on out_data with out_valid = 1 after edge N (the next cycle). This is one cycle when the buffer is empty or draining.
- Throughput: one transaction per cycle while out_ready = 1.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- Held output: while out_valid = 1 and out_ready = 0, out_data and out_inv must stay stable.
- Recovery from full: when out_ready drops with count = 2, in_ready drops. It rises the cycle after the first pop.

## Test plan
- NB=4, inverse: in_data = 8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, in_inv=1 -> out_data = 8e9f01c6_c64ddc01_01c6a158_9d01c6bc, out_inv=1, one cycle later.
- NB=4, forward on the same input, in_inv=0 -> 8e9f01c6_dc01c64d_01c6a158_c6bc9d01. Chaining forward then inverse (1000 random states, random direction order) must return the original state.
- NB=8, forward: bytes 00..1f ascending from MSB.
  - Row 2 must give 1314151617101112.
  - Row 3 must give 1c1d1e1f18191a1b.
  - Inverse of that result must restore the input.
- Backpressure: stream 5 transactions with out_ready=0 for 4 cycles.
  - After 2 accepts, in_ready=0 and the head stays stable.
  - On release, all 5 transactions come out in order at one per cycle with no loss or duplication.
- Reset mid-stream: assert rst with count=2 and in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1. The dropped transactions never appear.
- Random valid/ready toggling, NB=6, 10k transactions against a reference-model scoreboard: zero mismatches, and count never exceeds 2.
